// File: rtl/booth_sequencer.sv
// Control and add/subtract stage of a radix-2 Booth sequential multiplier.
// Optional macro BOOTH_WAIT_TIMEOUT_EN adds a WAIT-state watchdog and a timeout output.
module booth_sequencer #(
  parameter int N = 5,
  localparam int W = 2*N+1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           shift_enable,
  output logic [W-1:0]   shift_data,
  input  logic [W-1:0]   shift_out,
  input  logic           shift_ready,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done,
  output logic           op_err
`ifdef BOOTH_WAIT_TIMEOUT_EN
  ,
  output logic           timeout
`endif
);

  localparam int CW = $clog2(N+1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ADD, S_SHIFT, S_WAIT, S_DONE
  } state_t;

  state_t r_state, w_next_state;

  logic [N-1:0]   r_m, r_q;
  logic           r_m_min;
  logic [W-1:0]   r_word, r_shift_data;
  logic [CW-1:0]  r_count;
  logic [2*N-1:0] r_product;
  logic           r_op_err;

  logic           w_accept, w_last, w_wd_expire;
  logic [CW-1:0]  w_count_inc;
  logic [N-1:0]   w_a, w_a_next;

  assign w_accept    = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_count_inc = r_count + CW'(1);
  assign w_last      = (w_count_inc == CW'(N));
  assign w_a         = r_word[W-1:N+1];

  assign shift_data = r_shift_data;
  assign product    = r_product;
  assign op_err     = r_op_err;

`ifdef BOOTH_WAIT_TIMEOUT_EN
  logic [2:0] r_wd;
  logic       r_timeout;

  // Fires on the fourth consecutive WAIT cycle without a shifter response.
  assign w_wd_expire = (r_state == S_WAIT) && !shift_ready && (r_wd == 3'd3);
  assign timeout     = r_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wd_expire;
      if (r_state == S_SHIFT)
        r_wd <= '0;
      else if (r_state == S_WAIT && !shift_ready)
        r_wd <= r_wd + 3'd1;
    end
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    shift_enable = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_LOAD;
      S_LOAD: begin
        busy         = 1'b1;
        w_next_state = S_ADD;
      end
      S_ADD: begin
        busy         = 1'b1;
        w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        busy         = 1'b1;
        shift_enable = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (shift_ready)      w_next_state = w_last ? S_DONE : S_ADD;
        else if (w_wd_expire) w_next_state = S_IDLE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = start ? S_LOAD : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Booth recoding of {Q0, Q-1}: 10 subtracts M, 01 adds M, wrapping at N bits.
  always_comb begin
    w_a_next = w_a;
    case (r_word[1:0])
      2'b10:   w_a_next = w_a - r_m;
      2'b01:   w_a_next = w_a + r_m;
      default: w_a_next = w_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m          <= '0;
      r_q          <= '0;
      r_m_min      <= 1'b0;
      r_word       <= '0;
      r_shift_data <= '0;
      r_count      <= '0;
      r_product    <= '0;
      r_op_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_m      <= multiplicand;
        r_q      <= multiplier;
        r_m_min  <= (multiplicand == {1'b1, {(N-1){1'b0}}});
        r_op_err <= 1'b0;
      end
      case (r_state)
        S_LOAD: begin
          r_word  <= {{N{1'b0}}, r_q, 1'b0};
          r_count <= '0;
        end
        S_ADD: begin
          r_word       <= {w_a_next, r_word[N:0]};
          r_shift_data <= {w_a_next, r_word[N:0]};
        end
        S_WAIT: begin
          if (shift_ready) begin
            r_word  <= shift_out;
            r_count <= w_count_inc;
            if (w_last) begin
              // -2^(N-1) cannot be negated in N bits, so the result is suppressed.
              r_product <= r_m_min ? '0 : shift_out[W-1:1];
              r_op_err  <= r_m_min;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Self-checking bench for booth_sequencer: shifter model, scoreboard queue of
// expected products, latency/busy/pulse accounting; timeout case under BOOTH_WAIT_TIMEOUT_EN.
module tb_booth_sequencer;

  localparam int N = 5;
  localparam int W = 2*N+1;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           shift_enable;
  logic [W-1:0]   shift_data;
  logic [W-1:0]   shift_out;
  logic           shift_ready;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;
  logic           op_err;
  logic           timeout;

  booth_sequencer #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .shift_enable (shift_enable),
    .shift_data   (shift_data),
    .shift_out    (shift_out),
    .shift_ready  (shift_ready),
    .product      (product),
    .busy         (busy),
    .done         (done),
    .op_err       (op_err)
`ifdef BOOTH_WAIT_TIMEOUT_EN
    ,
    .timeout      (timeout)
`endif
  );

`ifndef BOOTH_WAIT_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  typedef struct {
    int prod;
    int err;
    int start_edge;
    int lat;
    int busy_cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_to     = 0;
  int busy_cyc = 0;
  int en_cnt   = 0;
  int ready_delay = 0;
  bit stray_en    = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "bench did not terminate");
  end

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int m, input int q, input int delay, input int se);
    exp_t e;
    if (m == -(1 << (N-1))) begin
      e.prod = 0;
      e.err  = 1;
    end else begin
      e.prod = m * q;
      e.err  = 0;
    end
    e.start_edge = se;
    e.lat        = 3*N + 2 + N*delay;
    e.busy_cyc   = 3*N + 1 + N*delay;
    return e;
  endfunction

  // Shift-stage model: answers ready_delay+1 cycles after shift_enable with the
  // arithmetic right shift of shift_data; optionally floods stray ready pulses
  // (random data) whenever no genuine answer is due.
  initial begin
    int          pend = 0;
    logic [W-1:0] pend_word = '0;
    shift_ready = 1'b0;
    shift_out   = '0;
    forever begin
      @(negedge clk);
      shift_ready = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          shift_ready = 1'b1;
          shift_out   = pend_word;
        end
      end else if (stray_en) begin
        shift_ready = 1'b1;
        shift_out   = W'($urandom);
      end
      if (rst_n && shift_enable) begin
        pend_word = {shift_data[W-1], shift_data[W-1:1]};
        pend      = 1 + ready_delay;
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      busy_cyc = 0;
      en_cnt   = 0;
    end else begin
      if (busy)         busy_cyc++;
      if (shift_enable) en_cnt++;
      if (timeout) begin
        n_to++;
        busy_cyc = 0;
        en_cnt   = 0;
      end
      if (done) begin
        n_done++;
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("product",      $signed(product), e.prod);
          check("op_err",       op_err, e.err);
          check("latency",      cyc - e.start_edge + 1, e.lat);
          check("busy_cycles",  busy_cyc, e.busy_cyc);
          check("shift_pulses", en_cnt, N);
        end
        busy_cyc = 0;
        en_cnt   = 0;
      end
    end
  end

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", done, 1);
  endtask

  task automatic run_op(input int m, input int q, input int delay, input bit stray);
    multiplicand = m[N-1:0];
    multiplier   = q[N-1:0];
    ready_delay  = delay;
    stray_en     = stray;
    start        = 1'b1;
    sb.push_back(model(m, q, delay, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    check("busy_on_accept", busy, 1);
    check("op_err_cleared", op_err, 0);
    wait_done(300);
    @(negedge clk);
    stray_en = 1'b0;
  endtask

  initial begin
    int k;
    int en_seen;
    int d0;
    int t0;
    logic [2*N-1:0] last_prod;

    rst_n        = 1'b0;
    start        = 1'b1;
    multiplicand = 5'd7;
    multiplier   = 5'd3;
    repeat (2) @(negedge clk);
    check("rst_busy",      busy, 0);
    check("rst_done",      done, 0);
    check("rst_shift_en",  shift_enable, 0);
    check("rst_shift_dat", shift_data, 0);
    check("rst_product",   product, 0);
    check("rst_op_err",    op_err, 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("start_in_reset_ignored", busy, 0);

    run_op(7, 3, 0, 1'b0);
    run_op(-6, 5, 0, 1'b0);
    run_op(5, -9, 0, 1'b0);
    run_op(-7, -8, 0, 1'b0);
    run_op(0, -16, 0, 1'b0);
    run_op(15, 15, 0, 1'b1);

    run_op(-16, 3, 0, 1'b0);
    check("op_err_held", op_err, 1);

    // Back-to-back: start stays high through the first DONE; operands change while busy.
    multiplicand = 5'd3;
    multiplier   = 5'd4;
    start        = 1'b1;
    sb.push_back(model(3, 4, 0, cyc + 1));
    @(negedge clk);
    multiplicand = 5'd2;
    multiplier   = 5'b11101;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b2b_first_done", done, 1);
    sb.push_back(model(2, -3, 0, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle_bubble", busy, 1);
    wait_done(100);
    @(negedge clk);

    // Abort in the third WAIT.
    multiplicand = 5'd3;
    multiplier   = 5'd5;
    start        = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    en_seen = 0;
    k       = 0;
    while (en_seen < 3 && k < 100) begin
      @(negedge clk);
      k++;
      if (shift_enable) en_seen++;
    end
    check("abort_reach_third_shift", en_seen, 3);
    @(negedge clk);
    d0    = n_done;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_done",     done, 0);
    check("abort_busy",     busy, 0);
    check("abort_product",  product, 0);
    check("abort_op_err",   op_err, 0);
    check("abort_shift_en", shift_enable, 0);
    check("abort_shift_dat", shift_data, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", n_done, d0);
    run_op(9, 11, 0, 1'b0);

    run_op(11, -7, 2, 1'b0);

`ifdef BOOTH_WAIT_TIMEOUT_EN
    last_prod    = product;
    d0           = n_done;
    t0           = n_to;
    ready_delay  = 4;
    multiplicand = 5'd8;
    multiplier   = 5'd8;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (n_to == t0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("timeout_pulses",  n_to - t0, 1);
    check("timeout_no_done", n_done, d0);
    check("timeout_idle",    busy, 0);
    check("timeout_product", product, last_prod);
    ready_delay = 0;
    repeat (10) @(negedge clk);
    run_op(4, 4, 0, 1'b0);
`else
    last_prod = '0;
    t0        = 0;
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
